// File: rtl/types.sv
// types: packet format shared by the bank and its ingress sources
package types;
  typedef enum logic [1:0] {
    CTRL_DATA    = 2'd0,
    CTRL_PARENTS = 2'd1,
    CTRL_CONFIG  = 2'd2,
    CTRL_RESULT  = 2'd3
  } ctrl_t;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
  } addr_t;
  typedef struct packed {
    ctrl_t       ctrl;
    addr_t       addr;
    logic [17:0] data;
  } pkt_t;
endpackage

// File: rtl/bank_ingress_arb.sv
// bank_ingress_arb: round-robin ingress arbiter into one bank, parents-load sequences kept atomic
module bank_ingress_arb
  import types::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  pkt_t [NUM_REQ-1:0]     req_pkt,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   bank_valid,
  output pkt_t                   bank_pkt,
  input  logic                   bank_ready,
  output logic                   locked,
  output logic [IDX_W-1:0]       lock_owner
);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d, last_q, last_d, grant_idx;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid, can_load, accept, out_valid_q, out_valid_d;
  pkt_t               out_pkt_q, out_pkt_d, grant_pkt;
  always_comb begin
    eligible = (state_q == LOCKED) ? (req_valid & (NUM_REQ'(1) << owner_q)) : req_valid;
  end
  // scan from farthest to nearest so the first eligible after last_q wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (eligible[(int'(last_q) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end
  always_comb begin
    can_load    = !out_valid_q || bank_ready;
    accept      = rst_n && can_load && grant_valid;
    grant_pkt   = req_pkt[grant_idx];
    req_ready   = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    out_valid_d = accept ? 1'b1 : (bank_ready ? 1'b0 : out_valid_q);
    out_pkt_d   = accept ? grant_pkt : out_pkt_q;
    last_d      = accept ? grant_idx : last_q;
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (accept && state_q == UNLOCKED && grant_pkt.ctrl == CTRL_PARENTS) begin
      state_d = LOCKED;
      owner_d = grant_idx;
    end else if (accept && state_q == LOCKED && grant_pkt.ctrl == CTRL_CONFIG) begin
      state_d = UNLOCKED;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      owner_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
    end
  end
  assign bank_valid = out_valid_q;
  assign bank_pkt   = out_pkt_q;
  assign locked     = (state_q == LOCKED);
  assign lock_owner = owner_q;
endmodule

// File: doc/bank_ingress_arb.md
Name: bank_ingress_arb

Overview:
- Shares the single packet input of one `bank` instance between NUM_REQ independent packet sources, e.g. the program loader and several router ports.
- Each source has its own valid/ready interface.
- Sources are arbitrated round-robin, and the winning packet goes through one registered output slice to the bank's router_valid_in/router_ready_in/router_in_pkt.
- A parents-load sequence (one or more CTRL_PARENTS packets followed by CTRL_CONFIG from the same source) is kept atomic, so the bank never sees another source's packets interleaved with it.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..16).
- IDX_W, $clog2(NUM_REQ), requester index width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-source packet valid.
- req_pkt  in  NUM_REQ x $bits(pkt_t)  per-source packet (types::pkt_t).
- req_ready  out  NUM_REQ  per-source accept; at most one bit high per cycle.
- bank_valid  out  1  to bank router_valid_in.
- bank_pkt  out  $bits(pkt_t)  to bank router_in_pkt.
- bank_ready  in  1  from bank router_ready_in.
- locked  out  1  a parents-load sequence is open.
- lock_owner  out  IDX_W  source holding the lock; valid only when locked=1.

Behaviour:
- Reset (rst_n=0, async):
  - bank_valid=0, bank_pkt=0, locked=0, lock_owner=0.
  - RR pointer last_grant=NUM_REQ-1, so source 0 has first priority.
  - req_ready=0 while in reset.
- Output slice: one register stage (out_valid, out_pkt).
  - can_load = !out_valid || bank_ready.
  - When can_load and a grant exists: the register loads the granted packet and the selected source sees req_ready=1 that cycle.
  - When bank_ready=1 and nothing is granted: out_valid clears.
  - Throughput is 1 packet/cycle. Latency from the req_valid&req_ready cycle to bank_valid=1 is 1 cycle.
  - While bank_valid=1 and bank_ready=0, bank_pkt is held stable and req_ready is all-zero.
- Eligibility:
  - Unlocked: source i is eligible iff req_valid[i]=1.
  - Locked: only i==lock_owner is eligible; all other sources stall even if valid.
- Grant: first eligible index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ. Combinational; req_ready[i] = can_load && grant_valid && grant_idx==i.
- last_grant updates to grant_idx only on an accepted packet. Held otherwise, including while bank_ready stalls.
- Lock FSM, states UNLOCKED and LOCKED, evaluated on each accepted packet:
  - UNLOCKED, accepted ctrl==CTRL_PARENTS -> LOCKED, lock_owner=grant_idx.
  - LOCKED, accepted ctrl==CTRL_PARENTS from owner -> stay LOCKED.
  - LOCKED, accepted ctrl==CTRL_CONFIG from owner -> UNLOCKED in the same edge. The CONFIG packet itself is forwarded.
  - Any other ctrl, or CTRL_CONFIG while UNLOCKED -> forwarded, no state change.
  - In LOCKED the RR pointer still updates, so after unlock priority resumes at lock_owner+1.
- Owner deasserting req_valid while LOCKED: the arbiter stays LOCKED with no timeout, and other sources wait. Sources must finish sequences they open.
- Simultaneous drain and load: with out_valid=1, bank_ready=1 and a grant, the old packet is consumed and the new one loaded on the same edge. No bubble.
- Reset mid-operation: async clear of the whole state. A held packet is dropped, and any open lock is discarded.
- The block never modifies packet contents; pkt fields pass through bit-exact.

Test Plan:
1. Single source: source 2 sends one CTRL_CONFIG, addr.z=5, with bank_ready=1 → req_ready[2]=1 in the send cycle; next cycle bank_valid=1 and bank_pkt equals the sent packet bit-exact; bank_valid=0 the cycle after.
2. Round-robin: all 4 sources continuously valid with non-lock ctrl, bank_ready=1 → accepted order 0,1,2,3,0,1; one packet/cycle, no idle cycles on bank_valid.
3. Atomic load: source 1 sends PARENTS, PARENTS, CONFIG back-to-back while sources 0 and 3 are valid → bank sees source 1's three packets contiguously; locked=1 and lock_owner=1 from the first accept until the CONFIG accept; the next grant goes to source 3, then 0.
4. Backpressure: while bank_valid=1 with packet P, hold bank_ready=0 for 3 cycles with sources 0 and 1 valid → bank_pkt stays P; req_ready=0 for all 3 cycles; last_grant unchanged; on bank_ready=1, P drains and the next source is loaded on the same edge.
5. Lock stall: source 0 sends PARENTS and then drops valid for 5 cycles while source 2 is valid → source 2 gets no req_ready for those 5 cycles; source 0 then sends CONFIG → unlock, and source 2 is granted next cycle.
6. Reset mid-lock: assert rst_n=0 asynchronously between clock edges while locked=1 and bank_valid=1 → outputs clear immediately; after release, source 0 has first priority and locked=0.
